// File: rtl/cgr_kmer_dump_pkg.sv
// -----------------------------------------------------------------------------
// cgr_pkg
// Shared definitions for the CGR k-mer counter readout path.
//   K       : default k-mer length in symbols
//   ADDR_W  : count RAM address width, {x[K-1:0], y[K-1:0]}
//   CNT_W   : default width of one count word
//   state_e : scan FSM states
//   addr_to_sym : recovers symbol idx of a k-mer from its CGR address
// -----------------------------------------------------------------------------
package cgr_pkg;

   localparam int K      = 8;
   localparam int ADDR_W = 2 * K;
   localparam int CNT_W  = 16;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      EVAL,
      EMIT,
      NEXT,
      DONE
   } state_e;

   // Bit idx of each address half holds symbol idx (bit 0 is the oldest).
   // The x half supplies the high symbol bit, the y half the low bit.
   // The optional k argument lets callers with a non-default K reuse it.
   function automatic logic [1:0] addr_to_sym(input logic [63:0] addr,
                                              input int          idx,
                                              input int          k = K);
      return {addr[k + idx], addr[idx]};
   endfunction

endpackage

// File: rtl/cgr_kmer_dump_if.sv
// -----------------------------------------------------------------------------
// cgr_kmer_dump_if
// Symbol stream leaving the k-mer dump: one 2-bit symbol per beat, K beats
// per k-mer, framed by sym_first/sym_last, with the k-mer count alongside.
//   sym_valid  : beat valid (source)
//   sym_ready  : beat accepted (sink)
//   sym_out    : symbol {a,b}
//   sym_first  : first symbol of a k-mer
//   sym_last   : last symbol of a k-mer
//   kmer_count : count of the k-mer in flight, stable for the whole k-mer
// -----------------------------------------------------------------------------
interface cgr_kmer_dump_if #(
   parameter int CNT_W = cgr_pkg::CNT_W
) ();

   logic             sym_valid;
   logic             sym_ready;
   logic [1:0]       sym_out;
   logic             sym_first;
   logic             sym_last;
   logic [CNT_W-1:0] kmer_count;

   modport master (
      output sym_valid,
      input  sym_ready,
      output sym_out,
      output sym_first,
      output sym_last,
      output kmer_count
   );

   modport slave (
      input  sym_valid,
      output sym_ready,
      input  sym_out,
      input  sym_first,
      input  sym_last,
      input  kmer_count
   );

endinterface

// File: rtl/cgr_kmer_dump_serializer.sv
// -----------------------------------------------------------------------------
// kmer_serializer
// Turns one latched CGR address into K symbols on a valid/ready stream,
// oldest symbol first.
//   CLK, RST : clock, asynchronous active-high reset
//   load     : capture addr/count and start emitting (one-cycle pulse)
//   addr     : CGR address of the k-mer to emit
//   count    : count to present on kmer_count for the whole k-mer
//   last_acc : the final symbol is being accepted this cycle
//   sym      : symbol stream (master side)
// -----------------------------------------------------------------------------
module kmer_serializer #(
   parameter int K     = cgr_pkg::K,
   parameter int CNT_W = cgr_pkg::CNT_W
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               load,
   input  logic [2*K-1:0]     addr,
   input  logic [CNT_W-1:0]   count,
   output logic               last_acc,
   cgr_kmer_dump_if.master    sym
);

   import cgr_pkg::addr_to_sym;

   localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

   logic             active;
   logic [IDX_W-1:0] sym_idx;
   logic [2*K-1:0]   addr_q;
   logic [CNT_W-1:0] count_q;
   logic             is_last;

   assign is_last = (sym_idx == IDX_W'(K - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         active  <= 1'b0;
         sym_idx <= '0;
         addr_q  <= '0;
         count_q <= '0;
      end else if (load) begin
         active  <= 1'b1;
         sym_idx <= '0;
         addr_q  <= addr;
         count_q <= count;
      end else if (active && sym.sym_ready) begin
         if (is_last) begin
            active <= 1'b0;
         end else begin
            sym_idx <= sym_idx + 1'b1;
         end
      end
   end

   // Outputs are pure functions of held registers, so they cannot change
   // while the sink stalls.
   assign sym.sym_valid  = active;
   assign sym.sym_out    = active ? addr_to_sym(64'(addr_q), int'(sym_idx), K) : 2'b00;
   assign sym.sym_first  = active && (sym_idx == '0);
   assign sym.sym_last   = active && is_last;
   assign sym.kmer_count = count_q;
   assign last_acc       = active && sym.sym_ready && is_last;

endmodule

// File: rtl/cgr_kmer_dump.sv
// -----------------------------------------------------------------------------
// cgr_kmer_dump
// Scans the CGR count RAM in ascending address order. Each address whose
// count is non-zero and >= threshold is decoded back to its k-mer and sent
// out as K symbols with its count. Optionally clears every scanned word.
//   CLK, RST    : clock, asynchronous active-high reset
//   start       : begin a scan (ignored while busy); latches threshold/clear_en
//   threshold   : minimum count to emit (0 behaves like 1)
//   clear_en    : write 0 to every scanned address
//   busy, done  : scan in progress / one-cycle completion pulse
//   ram_rd_en, ram_addr, ram_rd_data : synchronous RAM read (1-cycle latency)
//   ram_wr_en, ram_wr_data           : RAM clear write at ram_addr
//   sym         : k-mer symbol stream (master side)
// -----------------------------------------------------------------------------
module cgr_kmer_dump #(
   parameter int K     = cgr_pkg::K,
   parameter int CNT_W = cgr_pkg::CNT_W
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               start,
   input  logic [CNT_W-1:0]   threshold,
   input  logic               clear_en,
   output logic               busy,
   output logic               done,
   output logic               ram_rd_en,
   output logic [2*K-1:0]     ram_addr,
   input  logic [CNT_W-1:0]   ram_rd_data,
   output logic               ram_wr_en,
   output logic [CNT_W-1:0]   ram_wr_data,
   cgr_kmer_dump_if.master    sym
);

   localparam int ADDR_W = 2 * K;

   import cgr_pkg::*;

   state_e            state;
   state_e            state_nxt;

   // One spare bit so the scan counter can never wrap silently.
   logic [ADDR_W:0]   scan_addr;
   logic [CNT_W-1:0]  thr_q;
   logic              clr_q;

   logic [CNT_W-1:0]  thr_eff;
   logic              hit;
   logic              scan_end;
   logic              load;
   logic              last_acc;

   // Threshold 0 is treated as 1 so empty RAM words are never emitted.
   assign thr_eff  = (thr_q == '0) ? CNT_W'(1) : thr_q;
   assign hit      = (ram_rd_data != '0) && (ram_rd_data >= thr_eff);
   assign scan_end = (scan_addr[ADDR_W-1:0] == '1);

   // ---------------------------------------------------------------- state
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ----------------------------------------------------------- next state
   // NOTE: every combinational output gets a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (start)    state_nxt = READ;
         READ:               state_nxt = EVAL;
         EVAL:               state_nxt = hit ? EMIT : NEXT;
         EMIT: if (last_acc) state_nxt = NEXT;
         NEXT:               state_nxt = scan_end ? DONE : READ;
         DONE:               state_nxt = IDLE;
         default:            state_nxt = IDLE;
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      ram_rd_en = 1'b0;
      ram_wr_en = 1'b0;
      load      = 1'b0;
      unique case (state)
         IDLE: ;
         READ: begin
            busy      = 1'b1;
            ram_rd_en = 1'b1;
         end
         EVAL: begin
            busy      = 1'b1;
            ram_wr_en = clr_q;
            load      = hit;
         end
         EMIT, NEXT: busy = 1'b1;
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   assign ram_addr    = scan_addr[ADDR_W-1:0];
   assign ram_wr_data = '0;

   // ------------------------------------------------------------- datapath
   // Scan parameters are captured only when a scan is accepted, so a start
   // pulse during a scan neither restarts it nor changes its threshold.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         scan_addr <= '0;
         thr_q     <= '0;
         clr_q     <= 1'b0;
      end else if (state == IDLE && start) begin
         scan_addr <= '0;
         thr_q     <= threshold;
         clr_q     <= clear_en;
      end else if (state == NEXT && !scan_end) begin
         scan_addr <= scan_addr + 1'b1;
      end
   end

   kmer_serializer #(
      .K     (K),
      .CNT_W (CNT_W)
   ) u_ser (
      .CLK      (CLK),
      .RST      (RST),
      .load     (load),
      .addr     (scan_addr[ADDR_W-1:0]),
      .count    (ram_rd_data),
      .last_acc (last_acc),
      .sym      (sym)
   );

endmodule
